blackjack_hand_engine: RTL and testbench
========================================

Name: blackjack_hand_engine

Overview:
- Parametrised successor of the single-player blackjack FSM.
- Accumulates one hand from a card source via a request/ready handshake and resolves any number of soft aces.
- Configurable target score, win threshold, card limit and dealer (auto-play) mode.
- Sits between the card-deck/stimulus source and the display/result logic. Keeps the existing debug_state codes for option wait (4'b0010) and card wait (4'b0101).

Parameters:
- TARGET, 21: winning score; above it is a bust.
- WIN_MIN, 18: minimum score for a stand to count as victory.
- MAX_CARDS, 5: hand size that ends the game as victory when not bust ("charlie").
- INIT_CARDS, 2: cards dealt before the first option is sampled.
- DEALER_MODE, 0: 1 ignores opt and hits until hand >= DEALER_STAND.
- DEALER_STAND, 17: auto-stand threshold in dealer mode.
- HAND_W, 6: hand width; must hold TARGET+11.
- CNT_W, 4: width of nr_cards and soft_aces.

Ports:
- clk, in, 1: system clock, rising edge.
- rst, in, 1: synchronous reset, active-high.
- begin_s, in, 1: start game. Level; must drop after end_s before a new game starts.
- cval, in, 4: card value; 2..10 numeric/face, 11 = ace. 0, 1 and 12..15 are invalid.
- ready, in, 1: source strobe; qualifies cval in WAIT_CARD and opt in WAIT_OPT.
- opt, in, 1: player option; 1 = stand, 0 = hit.
- end_s, out, 1: game finished (high in DONE).
- request, out, 1: engine wants a card (high in WAIT_CARD).
- hand, out, HAND_W: current best hand value.
- soft_aces, out, CNT_W: aces currently counted as 11.
- nr_cards, out, CNT_W: cards accepted this game.
- victory, out, 1: result, valid while end_s = 1.
- defeat, out, 1: result, valid while end_s = 1.
- bad_card, out, 1: sticky; an invalid cval arrived with ready in WAIT_CARD.
- debug_state, out, 4: current state encoding.

Behaviour:
- All outputs are registered. On rst = 1 every output and internal register goes to 0 and the state goes to IDLE. This applies from any state, including mid-game.
- State encoding: IDLE 0000, INIT 0001, WAIT_OPT 0010, NORM 0011, ADD 0100, WAIT_CARD 0101, CHECK 0110, DONE 0111.
- IDLE: when begin_s = 1, go to INIT.
- INIT: clear hand, soft_aces, nr_cards, victory, defeat and bad_card; go to WAIT_CARD.
- WAIT_CARD: request = 1.
  - ready = 1 with a valid cval: latch cval and go to ADD.
  - ready = 1 with an invalid cval: set bad_card, stay in WAIT_CARD, card not counted.
  - ready = 0: stay.
- ADD (1 cycle):
  - hand <= hand + cval; nr_cards <= nr_cards + 1.
  - If cval = 11, soft_aces <= soft_aces + 1.
  - Go to NORM.
- NORM (at least 1 cycle, loops):
  - If hand > TARGET and soft_aces != 0: hand <= hand - 10, soft_aces <= soft_aces - 1, stay in NORM.
  - Otherwise go to CHECK.
  - Multiple aces need multiple passes (21 soft + ace = 32, passes to 22, then to 12).
- CHECK, evaluated in priority order:
  1. hand > TARGET: defeat = 1, go to DONE.
  2. hand == TARGET: victory = 1, go to DONE.
  3. nr_cards == MAX_CARDS: victory = 1, go to DONE.
  4. nr_cards < INIT_CARDS: go to WAIT_CARD.
  5. DEALER_MODE = 1 and hand >= DEALER_STAND: victory = 1, go to DONE.
  6. DEALER_MODE = 1 otherwise: go to WAIT_CARD.
  7. Otherwise: go to WAIT_OPT.
- WAIT_OPT: request = 0. When ready = 1, sample opt:
  - opt = 0: go to WAIT_CARD.
  - opt = 1: victory = (hand >= WIN_MIN), defeat = its complement, go to DONE.
- DONE:
  - end_s = 1; hand, nr_cards and the result flags are held.
  - When begin_s = 0, go to IDLE.
  - begin_s still high holds DONE; a new game never auto-starts.
- Latency: a card accepted at edge N is visible in hand at edge N+1. The next request rises at N+3 in the minimum case (one NORM pass, CHECK, then WAIT_CARD), plus one cycle per extra ace demotion.
- victory and defeat are never both 1.
- hand never exceeds TARGET+11 at any instant; there is no wrap.

Test Plan:
- Cards 11, 9 → hand 20, soft 1. opt 0, card 3 → 23 demoted to 13, soft 0. opt 0, card 5 → 18. opt 1 → end_s = 1, victory = 1, nr_cards = 4.
- Cards 10, 10, opt 0, card 5 → hand 25, defeat = 1, end_s = 1, no option requested after the bust.
- Cards 11, 10 → hand 21, victory after 2 cards, WAIT_OPT never entered.
- Cards 11, 11, opt 0, 11 → hands 22→12 (soft 1), then 23→13 (soft 2→1). Check the NORM loop cycle count.
- Cards 2, 2, 2, 2, 2 with opt 0 each time → hand 10, nr_cards 5, victory. Also cval = 0 with ready in WAIT_CARD → bad_card = 1, nr_cards unchanged.
- DEALER_MODE = 1: opt held at 1, cards 10, 6, 5 → hand 21, victory. Separately, rst pulsed in ADD → all outputs 0 next cycle, debug_state = 0000.

Source files
------------

// File: rtl/blackjack_hand_engine_if.sv
// Card-source / result bus of the blackjack hand engine.
// The master side is the card source and player, the slave side is the engine.
interface blackjack_hand_engine_if #(
    parameter int HAND_W = 6,
    parameter int CNT_W  = 4
);
    logic              begin_s;
    logic [3:0]        cval;
    logic              ready;
    logic              opt;
    logic              end_s;
    logic              request;
    logic [HAND_W-1:0] hand;
    logic [CNT_W-1:0]  soft_aces;
    logic [CNT_W-1:0]  nr_cards;
    logic              victory;
    logic              defeat;
    logic              bad_card;
    logic [3:0]        debug_state;

    modport master (
        output begin_s, cval, ready, opt,
        input  end_s, request, hand, soft_aces, nr_cards,
               victory, defeat, bad_card, debug_state
    );

    modport slave (
        input  begin_s, cval, ready, opt,
        output end_s, request, hand, soft_aces, nr_cards,
               victory, defeat, bad_card, debug_state
    );
endinterface

// File: rtl/blackjack_hand_engine.sv
// Blackjack hand engine: pulls cards over a ready/request handshake, keeps
// the best hand value with any number of soft aces, and resolves the game
// against a configurable target, win threshold, card limit and dealer rule.
module blackjack_hand_engine #(
    parameter int TARGET       = 21,
    parameter int WIN_MIN      = 18,
    parameter int MAX_CARDS    = 5,
    parameter int INIT_CARDS   = 2,
    parameter int DEALER_MODE  = 0,
    parameter int DEALER_STAND = 17,
    parameter int HAND_W       = 6,
    parameter int CNT_W        = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    blackjack_hand_engine_if.slave  bus
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'b0000,
        S_INIT      = 4'b0001,
        S_WAIT_OPT  = 4'b0010,
        S_NORM      = 4'b0011,
        S_ADD       = 4'b0100,
        S_WAIT_CARD = 4'b0101,
        S_CHECK     = 4'b0110,
        S_DONE      = 4'b0111
    } state_t;

    localparam logic [HAND_W-1:0] TARGET_H = HAND_W'(TARGET);
    localparam logic [HAND_W-1:0] WIN_H    = HAND_W'(WIN_MIN);
    localparam logic [HAND_W-1:0] STAND_H  = HAND_W'(DEALER_STAND);
    localparam logic [HAND_W-1:0] TEN_H    = HAND_W'(10);
    localparam logic [CNT_W-1:0]  MAXC_C   = CNT_W'(MAX_CARDS);
    localparam logic [CNT_W-1:0]  INITC_C  = CNT_W'(INIT_CARDS);
    localparam logic [CNT_W-1:0]  ONE_C    = CNT_W'(1);

    state_t            state_q, state_d;
    logic [HAND_W-1:0] hand_q, hand_d;
    logic [CNT_W-1:0]  soft_q, soft_d;
    logic [CNT_W-1:0]  nr_q, nr_d;
    logic [3:0]        card_q, card_d;
    logic              vic_q, vic_d;
    logic              def_q, def_d;
    logic              bad_q, bad_d;
    logic              req_q, req_d;
    logic              end_q, end_d;

    // Only 2..11 are real cards; everything else is flagged and dropped.
    function automatic logic card_valid(input logic [3:0] v);
        return (v >= 4'd2) && (v <= 4'd11);
    endfunction

    // Hard value of the latched card added to the running hand.
    function automatic logic [HAND_W-1:0] add_card(input logic [HAND_W-1:0] h,
                                                   input logic [3:0] c);
        return h + HAND_W'(c);
    endfunction

    // Next-state and next-value logic for the game sequencer.
    always_comb begin
        state_d = state_q;
        hand_d  = hand_q;
        soft_d  = soft_q;
        nr_d    = nr_q;
        card_d  = card_q;
        vic_d   = vic_q;
        def_d   = def_q;
        bad_d   = bad_q;
        case (state_q)
            S_IDLE: begin
                if (bus.begin_s) state_d = S_INIT;
            end
            S_INIT: begin
                hand_d  = '0;
                soft_d  = '0;
                nr_d    = '0;
                vic_d   = 1'b0;
                def_d   = 1'b0;
                bad_d   = 1'b0;
                state_d = S_WAIT_CARD;
            end
            S_WAIT_CARD: begin
                if (bus.ready) begin
                    if (card_valid(bus.cval)) begin
                        card_d  = bus.cval;
                        state_d = S_ADD;
                    end else begin
                        bad_d = 1'b1;
                    end
                end
            end
            S_ADD: begin
                hand_d = add_card(hand_q, card_q);
                nr_d   = nr_q + ONE_C;
                if (card_q == 4'd11) soft_d = soft_q + ONE_C;
                state_d = S_NORM;
            end
            S_NORM: begin
                // One ace demoted from 11 to 1 per pass until not bust.
                if ((hand_q > TARGET_H) && (soft_q != '0)) begin
                    hand_d = hand_q - TEN_H;
                    soft_d = soft_q - ONE_C;
                end else begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (hand_q > TARGET_H) begin
                    def_d   = 1'b1;
                    state_d = S_DONE;
                end else if (hand_q == TARGET_H) begin
                    vic_d   = 1'b1;
                    state_d = S_DONE;
                end else if (nr_q == MAXC_C) begin
                    vic_d   = 1'b1;
                    state_d = S_DONE;
                end else if (nr_q < INITC_C) begin
                    state_d = S_WAIT_CARD;
                end else if ((DEALER_MODE != 0) && (hand_q >= STAND_H)) begin
                    vic_d   = 1'b1;
                    state_d = S_DONE;
                end else if (DEALER_MODE != 0) begin
                    state_d = S_WAIT_CARD;
                end else begin
                    state_d = S_WAIT_OPT;
                end
            end
            S_WAIT_OPT: begin
                if (bus.ready) begin
                    if (!bus.opt) begin
                        state_d = S_WAIT_CARD;
                    end else begin
                        vic_d   = (hand_q >= WIN_H);
                        def_d   = !(hand_q >= WIN_H);
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (!bus.begin_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        req_d = (state_d == S_WAIT_CARD);
        end_d = (state_d == S_DONE);
    end

    // State and output registers, all cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            hand_q  <= '0;
            soft_q  <= '0;
            nr_q    <= '0;
            card_q  <= '0;
            vic_q   <= 1'b0;
            def_q   <= 1'b0;
            bad_q   <= 1'b0;
            req_q   <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hand_q  <= hand_d;
            soft_q  <= soft_d;
            nr_q    <= nr_d;
            card_q  <= card_d;
            vic_q   <= vic_d;
            def_q   <= def_d;
            bad_q   <= bad_d;
            req_q   <= req_d;
            end_q   <= end_d;
        end
    end

    assign bus.end_s       = end_q;
    assign bus.request     = req_q;
    assign bus.hand        = hand_q;
    assign bus.soft_aces   = soft_q;
    assign bus.nr_cards    = nr_q;
    assign bus.victory     = vic_q;
    assign bus.defeat      = def_q;
    assign bus.bad_card    = bad_q;
    assign bus.debug_state = state_q;

endmodule

// File: tb/tb_blackjack_hand_engine.sv
// Bench for the blackjack hand engine: directed games from the test plan and
// randomized games, checked against a card-history model of the hand.
module tb_blackjack_hand_engine;

    localparam int TGT    = 21;
    localparam int WIN    = 18;
    localparam int MAXC   = 5;
    localparam int INITC  = 2;
    localparam int DSTAND = 17;

    localparam int EV_NONE = 0;
    localparam int EV_REQ  = 1;
    localparam int EV_OPT  = 2;
    localparam int EV_END  = 3;

    logic       clk = 1'b0;
    logic       rst, beg, rdy, op, sel;
    logic [3:0] cv;
    int         total = 0;
    int         bad   = 0;
    int         cq[$];
    int         oq[$];

    always #5 clk = ~clk;

    blackjack_hand_engine_if #(.HAND_W(6), .CNT_W(4)) bif0 ();
    blackjack_hand_engine_if #(.HAND_W(6), .CNT_W(4)) bif1 ();

    blackjack_hand_engine u_dut (.clk(clk), .rst(rst), .bus(bif0));
    blackjack_hand_engine #(.DEALER_MODE(1)) u_dlr (.clk(clk), .rst(rst), .bus(bif1));

    assign bif0.begin_s = sel ? 1'b0 : beg;
    assign bif0.ready   = sel ? 1'b0 : rdy;
    assign bif0.cval    = cv;
    assign bif0.opt     = op;
    assign bif1.begin_s = sel ? beg : 1'b0;
    assign bif1.ready   = sel ? rdy : 1'b0;
    assign bif1.cval    = cv;
    assign bif1.opt     = op;

    logic [5:0] o_hand;
    logic [3:0] o_soft, o_nr, o_dbg;
    logic       o_end, o_req, o_vic, o_def, o_bad;
    assign o_hand = sel ? bif1.hand        : bif0.hand;
    assign o_soft = sel ? bif1.soft_aces   : bif0.soft_aces;
    assign o_nr   = sel ? bif1.nr_cards    : bif0.nr_cards;
    assign o_dbg  = sel ? bif1.debug_state : bif0.debug_state;
    assign o_end  = sel ? bif1.end_s       : bif0.end_s;
    assign o_req  = sel ? bif1.request     : bif0.request;
    assign o_vic  = sel ? bif1.victory     : bif0.victory;
    assign o_def  = sel ? bif1.defeat      : bif0.defeat;
    assign o_bad  = sel ? bif1.bad_card    : bif0.bad_card;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Best blackjack value of a hand from its card sum and ace count.
    task automatic eval_hand(input int s, input int a, output int h, output int sf, output int dm);
        h = s; sf = a; dm = 0;
        while (h > TGT && sf > 0) begin
            h -= 10; sf--; dm++;
        end
    endtask

    function automatic int next_after_card(input int h, input int n, input bit dealer);
        if (h >= TGT || n == MAXC) return EV_END;
        if (n < INITC) return EV_REQ;
        if (dealer) return (h >= DSTAND) ? EV_END : EV_REQ;
        return EV_OPT;
    endfunction

    function automatic logic [3:0] pick_invalid();
        int k;
        k = $urandom_range(0, 5);
        return (k < 2) ? 4'(k) : 4'(k + 10);
    endfunction

    task automatic wait_event(output int ev, output int cyc);
        ev = EV_NONE; cyc = 0;
        while (ev == EV_NONE && cyc < 40) begin
            @(negedge clk);
            cyc++;
            rdy = 1'b0;
            if (o_end) ev = EV_END;
            else if (o_req) ev = EV_REQ;
            else if (o_dbg == 4'b0010) ev = EV_OPT;
        end
    endtask

    // One full game; inj: 0 no bad cards, 1 a cval of 0 before the first card, 2 random.
    task automatic play(input int inj);
        int n = 0, s = 0, a = 0, h = 0, sf = 0, dm = 0, dm_old = 0;
        int ev, cyc, exp_ev, c, o, it;
        bit bad_exp = 0, vic_exp = 0, def_exp = 0, dealer;
        dealer = sel;
        op = dealer;
        beg = 1'b1;
        wait_event(ev, cyc);
        chk("start_event", ev, EV_REQ);
        chk("start_latency", cyc, 2);
        chk("init_hand", o_hand, 0);
        chk("init_nr", o_nr, 0);
        chk("init_soft", o_soft, 0);
        chk("init_bad", o_bad, 0);
        chk("init_result", {o_vic, o_def}, 0);
        exp_ev = EV_REQ;
        it = 0;
        while (ev == exp_ev && ev != EV_END && it < 20) begin
            it++;
            if (ev == EV_REQ) begin
                if ((inj == 1 && n == 0) || (inj == 2 && $urandom_range(0, 5) == 0)) begin
                    cv  = (inj == 1) ? 4'd0 : pick_invalid();
                    rdy = 1'b1;
                    @(negedge clk);
                    rdy = 1'b0;
                    bad_exp = 1;
                    chk("bad_flag", o_bad, 1);
                    chk("bad_still_request", o_req, 1);
                    chk("bad_nr_unchanged", o_nr, n);
                end
                c = (cq.size() > 0) ? cq.pop_front() : int'($urandom_range(2, 11));
                cv  = 4'(c);
                rdy = 1'b1;
                n++; s += c;
                if (c == 11) a++;
                dm_old = dm;
                eval_hand(s, a, h, sf, dm);
                exp_ev = next_after_card(h, n, dealer);
                if (exp_ev == EV_END) begin
                    def_exp = (h > TGT);
                    vic_exp = !def_exp;
                end
                wait_event(ev, cyc);
                chk("card_event", ev, exp_ev);
                chk("card_latency", cyc, 4 + dm - dm_old);
                chk("card_hand", o_hand, h);
                chk("card_soft", o_soft, sf);
                chk("card_nr", o_nr, n);
                chk("card_bad", o_bad, bad_exp);
            end else begin
                o = dealer ? 1 : ((oq.size() > 0) ? oq.pop_front() : int'($urandom_range(0, 1)));
                op  = o[0];
                rdy = 1'b1;
                if (o != 0) begin
                    exp_ev  = EV_END;
                    vic_exp = (h >= WIN);
                    def_exp = !vic_exp;
                end else begin
                    exp_ev = EV_REQ;
                end
                wait_event(ev, cyc);
                chk("opt_event", ev, exp_ev);
                chk("opt_latency", cyc, 1);
            end
        end
        if (ev == EV_END && exp_ev == EV_END) begin
            chk("end_victory", o_vic, vic_exp);
            chk("end_defeat", o_def, def_exp);
            chk("end_hand", o_hand, h);
            chk("end_nr", o_nr, n);
            @(negedge clk);
            chk("done_holds", {o_end, o_dbg}, {1'b1, 4'b0111});
        end else begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end
        beg = 1'b0;
        it = 0;
        while (o_dbg != 4'b0000 && it < 5) begin
            @(negedge clk);
            it++;
        end
        chk("back_idle", o_dbg, 0);
        chk("idle_end_low", o_end, 0);
        cq.delete();
        oq.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ev, cyc;
        rst = 1'b1; beg = 1'b0; rdy = 1'b0; op = 1'b0; cv = 4'd0; sel = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", o_dbg, 0);
        chk("rst_hand", o_hand, 0);
        chk("rst_flags", {o_end, o_req, o_vic, o_def, o_bad}, 0);
        chk("rst_counts", {o_nr, o_soft}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Soft ace survives, then demotes on the third card; stand on 18.
        cq = '{11, 9, 3, 5};    oq = '{0, 0, 1};  play(0);
        // Bust on 25 with no option afterwards.
        cq = '{10, 10, 5};      oq = '{0};        play(0);
        // Natural 21 on two cards.
        cq = '{11, 10};                           play(0);
        // Three aces: two single demotions, then stand on 13.
        cq = '{11, 11, 11};     oq = '{0, 1};     play(0);
        // Five-card charlie with an invalid card first.
        cq = '{2, 2, 2, 2, 2};  oq = '{0, 0, 0};  play(1);

        // Reset while the second card is being added.
        beg = 1'b1;
        wait_event(ev, cyc);
        cv = 4'd10; rdy = 1'b1;
        wait_event(ev, cyc);
        chk("radd_first_hand", o_hand, 10);
        cv = 4'd5; rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        chk("radd_in_add", o_dbg, 4);
        rst = 1'b1;
        @(negedge clk);
        chk("radd_state", o_dbg, 0);
        chk("radd_hand", o_hand, 0);
        chk("radd_nr", o_nr, 0);
        chk("radd_flags", {o_end, o_req, o_vic, o_def, o_bad, o_soft}, 0);
        beg = 1'b0; rst = 1'b0;
        @(negedge clk);

        for (int g = 0; g < 20; g++) play(2);

        // Dealer-mode engine: opt ignored, stands from 17.
        sel = 1'b1;
        @(negedge clk);
        cq = '{10, 6, 5};                         play(0);
        for (int g = 0; g < 10; g++) play(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
